// File: rtl/sound_frame_sequencer_if.sv
// Register-side controls and timing outputs for one square-wave channel sequencer.
// The master drives the NRx register strobes; the slave returns ticks and channel state.
interface sound_frame_sequencer_if;
    logic       I_SOUND_EN;
    logic       I_TRIGGER;
    logic       I_LENGTH_LOAD;
    logic [5:0] I_LENGTH_DATA;
    logic       I_LENGTH_EN;
    logic [3:0] I_ENV_INIT;
    logic       I_ENV_INC;
    logic [2:0] I_ENV_PERIOD;
    logic       O_CH_ON;
    logic [3:0] O_VOLUME;
    logic [2:0] O_FRAME_STEP;
    logic       O_LENGTH_TICK;
    logic       O_SWEEP_TICK;
    logic       O_ENV_TICK;

    modport master (
        output I_SOUND_EN, I_TRIGGER, I_LENGTH_LOAD, I_LENGTH_DATA,
        output I_LENGTH_EN, I_ENV_INIT, I_ENV_INC, I_ENV_PERIOD,
        input  O_CH_ON, O_VOLUME, O_FRAME_STEP,
        input  O_LENGTH_TICK, O_SWEEP_TICK, O_ENV_TICK
    );

    modport slave (
        input  I_SOUND_EN, I_TRIGGER, I_LENGTH_LOAD, I_LENGTH_DATA,
        input  I_LENGTH_EN, I_ENV_INIT, I_ENV_INC, I_ENV_PERIOD,
        output O_CH_ON, O_VOLUME, O_FRAME_STEP,
        output O_LENGTH_TICK, O_SWEEP_TICK, O_ENV_TICK
    );
endinterface

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer with length counter and volume envelope for one
// square-wave channel; tick pulses are shared with sibling channels.
module sound_frame_sequencer #(
    parameter int CLK_DIV = 8192
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET_L,
    sound_frame_sequencer_if.slave bus
);
    localparam int              PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_step;
    logic          r_len_tick;
    logic          r_sweep_tick;
    logic          r_env_tick;
    logic          r_ch_on;
    logic [3:0]    r_vol;
    logic [6:0]    r_len_rem;
    logic [2:0]    r_env_cnt;

    logic          w_wrap;
    logic          w_len_ev;
    logic          w_env_ev;
    logic          w_dac_on;
    logic [6:0]    w_load_val;
    logic [6:0]    w_rem_base;
    logic [3:0]    w_vol_step;

    assign w_wrap     = (r_presc == LAST);
    assign w_len_ev   = w_wrap & ~r_step[0];
    assign w_env_ev   = w_wrap & (r_step == 3'd7);
    assign w_dac_on   = (bus.I_ENV_INIT != 4'd0) | bus.I_ENV_INC;
    assign w_load_val = 7'd64 - {1'b0, bus.I_LENGTH_DATA};
    // A trigger sharing the edge with a length load sees the freshly loaded value
    assign w_rem_base = bus.I_LENGTH_LOAD ? w_load_val : r_len_rem;

    always_comb begin
        w_vol_step = r_vol;
        if (bus.I_ENV_INC) begin
            if (r_vol != 4'd15) w_vol_step = r_vol + 4'd1;
        end else begin
            if (r_vol != 4'd0)  w_vol_step = r_vol - 4'd1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_presc      <= '0;
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end else if (!bus.I_SOUND_EN) begin
            r_presc      <= '0;
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end else begin
            r_presc      <= w_wrap ? '0 : r_presc + PW'(1);
            if (w_wrap) r_step <= r_step + 3'd1;
            r_len_tick   <= w_len_ev;
            r_sweep_tick <= w_wrap & (r_step[1:0] == 2'b10);
            r_env_tick   <= w_env_ev;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_ch_on   <= 1'b0;
            r_len_rem <= 7'd0;
        end else if (!bus.I_SOUND_EN) begin
            r_ch_on   <= 1'b0;
            r_len_rem <= 7'd0;
        end else if (bus.I_TRIGGER) begin
            r_ch_on   <= w_dac_on;
            r_len_rem <= (w_rem_base == 7'd0) ? 7'd64 : w_rem_base;
        end else if (bus.I_LENGTH_LOAD) begin
            r_len_rem <= w_load_val;
        end else if (w_len_ev && bus.I_LENGTH_EN && r_len_rem != 7'd0) begin
            r_len_rem <= r_len_rem - 7'd1;
            if (r_len_rem == 7'd1) r_ch_on <= 1'b0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_vol     <= 4'd0;
            r_env_cnt <= 3'd0;
        end else if (!bus.I_SOUND_EN) begin
            r_vol     <= 4'd0;
        end else if (bus.I_TRIGGER) begin
            r_vol     <= bus.I_ENV_INIT;
            r_env_cnt <= bus.I_ENV_PERIOD;
        end else if (w_env_ev && bus.I_ENV_PERIOD != 3'd0) begin
            if (r_env_cnt > 3'd1) begin
                r_env_cnt <= r_env_cnt - 3'd1;
            end else begin
                r_env_cnt <= bus.I_ENV_PERIOD;
                r_vol     <= w_vol_step;
            end
        end
    end

    assign bus.O_CH_ON       = r_ch_on;
    assign bus.O_VOLUME      = r_vol;
    assign bus.O_FRAME_STEP  = r_step;
    assign bus.O_LENGTH_TICK = r_len_tick;
    assign bus.O_SWEEP_TICK  = r_sweep_tick;
    assign bus.O_ENV_TICK    = r_env_tick;
endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with a 4-cycle frame step.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_sound_frame_sequencer;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sound_frame_sequencer_if bus();

    sound_frame_sequencer #(.CLK_DIV(DIV)) dut (
        .I_CLK    (clk),
        .I_RESET_L(rst_n),
        .bus      (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Advance until the edge just taken satisfies cyc % m == r
    task automatic run_to(input int m, input int r);
        do step(); while (cyc % m != r);
    endtask

    task automatic trig(input logic load);
        bus.I_TRIGGER     = 1'b1;
        bus.I_LENGTH_LOAD = load;
        step();
        bus.I_TRIGGER     = 1'b0;
        bus.I_LENGTH_LOAD = 1'b0;
    endtask

    task automatic set_env(input logic [3:0] init, input logic inc,
                           input logic [2:0] per);
        bus.I_ENV_INIT   = init;
        bus.I_ENV_INC    = inc;
        bus.I_ENV_PERIOD = per;
    endtask

    initial begin
        logic [3:0] exp_vol [6];
        logic [5:0] frm;
        logic [5:0] exp_frm;

        bus.I_SOUND_EN    = 1'b0;
        bus.I_TRIGGER     = 1'b0;
        bus.I_LENGTH_LOAD = 1'b0;
        bus.I_LENGTH_DATA = 6'd0;
        bus.I_LENGTH_EN   = 1'b0;
        set_env(4'd0, 1'b0, 3'd0);

        repeat (3) @(negedge clk);
        chk("rst_ch_on", bus.O_CH_ON, 0);
        chk("rst_vol", bus.O_VOLUME, 0);
        rst_n = 1'b1;
        step();
        chk("rst_step", bus.O_FRAME_STEP, 0);
        chk("rst_ticks", {bus.O_LENGTH_TICK, bus.O_SWEEP_TICK, bus.O_ENV_TICK}, 0);

        // Frame sequencer timing from sound enable
        bus.I_SOUND_EN = 1'b1;
        cyc = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            frm = {bus.O_LENGTH_TICK, bus.O_SWEEP_TICK, bus.O_ENV_TICK,
                   bus.O_FRAME_STEP};
            exp_frm = {(e % 8 == 4), (e % 16 == 12), (e % 32 == 0),
                       3'((e / 4) % 8)};
            chk($sformatf("frame_e%0d", e), frm, exp_frm);
        end

        // Length: 64-62 = 2 ticks
        set_env(4'd5, 1'b0, 3'd0);
        bus.I_LENGTH_DATA = 6'd62;
        bus.I_LENGTH_EN   = 1'b1;
        trig(1'b1);
        chk("len_on", bus.O_CH_ON, 1);
        chk("len_vol", bus.O_VOLUME, 5);
        run_to(8, 4);
        chk("len_tick", bus.O_LENGTH_TICK, 1);
        chk("len_1st", bus.O_CH_ON, 1);
        run_to(8, 4);
        chk("len_2nd", bus.O_CH_ON, 0);

        // Retrigger with remaining 0 reloads 64
        trig(1'b0);
        chk("len64_on", bus.O_CH_ON, 1);
        for (int k = 1; k <= 64; k++) begin
            run_to(8, 4);
            if (k == 63) chk("len64_63", bus.O_CH_ON, 1);
            if (k == 64) chk("len64_64", bus.O_CH_ON, 0);
        end

        // Envelope decrement, period 1, saturate at 0
        bus.I_LENGTH_EN = 1'b0;
        set_env(4'd2, 1'b0, 3'd1);
        trig(1'b0);
        chk("envdn_v0", bus.O_VOLUME, 2);
        exp_vol = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int k = 0; k < 3; k++) begin
            run_to(32, 0);
            chk($sformatf("envdn_v%0d", k + 1), bus.O_VOLUME, exp_vol[k]);
        end
        chk("envdn_on", bus.O_CH_ON, 1);

        // Envelope increment saturates at 15
        set_env(4'd14, 1'b1, 3'd1);
        trig(1'b0);
        run_to(32, 0);
        chk("envup_1", bus.O_VOLUME, 15);
        run_to(32, 0);
        chk("envup_2", bus.O_VOLUME, 15);
        chk("envup_on", bus.O_CH_ON, 1);

        // Period 3: volume moves on every third env tick
        set_env(4'd8, 1'b0, 3'd3);
        trig(1'b0);
        exp_vol = '{4'd8, 4'd8, 4'd7, 4'd7, 4'd7, 4'd6};
        for (int k = 0; k < 6; k++) begin
            run_to(32, 0);
            chk($sformatf("envp3_%0d", k), bus.O_VOLUME, exp_vol[k]);
        end

        // Period 0 freezes the envelope
        set_env(4'd8, 1'b0, 3'd0);
        trig(1'b0);
        for (int k = 0; k < 3; k++) begin
            run_to(32, 0);
            chk($sformatf("envp0_%0d", k), bus.O_VOLUME, 8);
        end

        // Trigger on an envelope edge suppresses that step
        set_env(4'd6, 1'b0, 3'd1);
        run_to(32, 31);
        trig(1'b0);
        chk("envsup_tick", bus.O_ENV_TICK, 1);
        chk("envsup_v", bus.O_VOLUME, 6);
        run_to(32, 0);
        chk("envsup_next", bus.O_VOLUME, 5);

        // DAC off keeps the channel disabled
        set_env(4'd0, 1'b0, 3'd0);
        trig(1'b0);
        chk("dac_off", bus.O_CH_ON, 0);

        // Trigger coincident with a length tick: no decrement that edge
        set_env(4'd3, 1'b0, 3'd0);
        bus.I_LENGTH_DATA = 6'd60;
        bus.I_LENGTH_EN   = 1'b1;
        run_to(8, 0);
        trig(1'b1);
        chk("lsup_on", bus.O_CH_ON, 1);
        run_to(8, 3);
        trig(1'b0);
        chk("lsup_tick", bus.O_LENGTH_TICK, 1);
        for (int k = 1; k <= 4; k++) begin
            run_to(8, 4);
            if (k == 3) chk("lsup_3", bus.O_CH_ON, 1);
            if (k == 4) chk("lsup_4", bus.O_CH_ON, 0);
        end

        // Asynchronous reset mid-note
        bus.I_LENGTH_EN = 1'b0;
        set_env(4'd9, 1'b0, 3'd0);
        trig(1'b0);
        run_to(32, 12);
        chk("arst_pre_on", bus.O_CH_ON, 1);
        chk("arst_pre_vol", bus.O_VOLUME, 9);
        chk("arst_pre_step", bus.O_FRAME_STEP, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_on", bus.O_CH_ON, 0);
        chk("arst_vol", bus.O_VOLUME, 0);
        chk("arst_step", bus.O_FRAME_STEP, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (3) step();
        chk("arst_t3", bus.O_LENGTH_TICK, 0);
        step();
        chk("arst_t4", {bus.O_LENGTH_TICK, bus.O_FRAME_STEP}, {1'b1, 3'd1});

        // Sound enable drop clears channel and sequencer
        trig(1'b0);
        run_to(8, 6);
        chk("en_pre_on", bus.O_CH_ON, 1);
        chk("en_pre_step", bus.O_FRAME_STEP, 1);
        bus.I_SOUND_EN = 1'b0;
        step();
        chk("en_off_on", bus.O_CH_ON, 0);
        chk("en_off_step", bus.O_FRAME_STEP, 0);
        chk("en_off_vol", bus.O_VOLUME, 0);
        trig(1'b1);
        chk("en_off_trig", bus.O_CH_ON, 0);
        bus.I_SOUND_EN = 1'b1;
        cyc = 0;
        repeat (3) step();
        chk("en_t3", bus.O_LENGTH_TICK, 0);
        step();
        chk("en_t4", {bus.O_LENGTH_TICK, bus.O_FRAME_STEP}, {1'b1, 3'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
